// File: rtl/slot_route_engine_if.sv
// Instruction handshake between a sequencer and the slot route engine.
// The instruction layout is {op, delay, dst, src} with src in the LSBs.
interface slot_route_engine_if #(
    parameter int WIDTH   = 4,
    parameter int SLOTS   = 8,
    parameter int DELAY_W = 3
);
    localparam int SEL_W   = $clog2(SLOTS);
    localparam int INSTR_W = 2 + DELAY_W + 2 * SEL_W;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;

    modport master (output instr_valid, output instr, input  instr_ready);
    modport slave  (input  instr_valid, input  instr, output instr_ready);
endinterface

// File: rtl/slot_route_engine.sv
// Instruction-driven slot router: captures one input word, then after a
// programmable delay commits MOVE/ADD/ISOLATE/CLEAR results into a slot buffer.
module slot_route_lane #(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       op,
    input  logic             is_dst,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] hold,
    output logic [WIDTH-1:0] nxt
);
    localparam logic [1:0] OP_MOVE = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_ISO  = 2'b10;

    always_comb begin
        nxt = cur;
        case (op)
            OP_MOVE: if (is_dst) nxt = hold;
            OP_ADD:  if (is_dst) nxt = cur + hold;
            OP_ISO:  nxt = is_dst ? hold : '0;
            default: nxt = '0;
        endcase
    end
endmodule

module slot_route_engine #(
    parameter int WIDTH   = 4,
    parameter int SLOTS   = 8,
    parameter int DELAY_W = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    slot_route_engine_if.slave     bus,
    input  logic [SLOTS*WIDTH-1:0] inp,
    output logic [SLOTS*WIDTH-1:0] out,
    output logic                   done,
    output logic                   carry
);
    localparam int SEL_W   = $clog2(SLOTS);
    localparam int INSTR_W = 2 + DELAY_W + 2 * SEL_W;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b01;

    logic [1:0]                   state_q;
    logic [SLOTS-1:0][WIDTH-1:0]  inp_w, slot_q, slot_nxt;
    logic [WIDTH-1:0]             hold_q;
    logic [1:0]                   op_q;
    logic [SEL_W-1:0]             dst_q;
    logic [DELAY_W-1:0]           cnt_q;
    logic [WIDTH:0]               add_full;

    logic [SEL_W-1:0]   i_src, i_dst;
    logic [DELAY_W-1:0] i_delay;
    logic [1:0]         i_op;

    assign i_src   = bus.instr[SEL_W-1:0];
    assign i_dst   = bus.instr[2*SEL_W-1:SEL_W];
    assign i_delay = bus.instr[2*SEL_W +: DELAY_W];
    assign i_op    = bus.instr[INSTR_W-1 -: 2];

    assign inp_w           = inp;
    assign out             = slot_q;
    assign bus.instr_ready = (state_q == IDLE);

    // Carry is taken from the destination slot as it stands at commit time.
    assign add_full = {1'b0, slot_q[dst_q]} + {1'b0, hold_q};

    for (genvar g = 0; g < SLOTS; g++) begin : g_lane
        slot_route_lane #(.WIDTH(WIDTH)) u_lane (
            .op     (op_q),
            .is_dst (dst_q == SEL_W'(g)),
            .cur    (slot_q[g]),
            .hold   (hold_q),
            .nxt    (slot_nxt[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            slot_q  <= '0;
            hold_q  <= '0;
            op_q    <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            done    <= 1'b0;
            carry   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: if (bus.instr_valid) begin
                    hold_q  <= inp_w[i_src];
                    op_q    <= i_op;
                    dst_q   <= i_dst;
                    cnt_q   <= i_delay;
                    state_q <= (i_delay == '0) ? COMMIT : WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == DELAY_W'(1)) state_q <= COMMIT;
                end
                COMMIT: begin
                    slot_q  <= slot_nxt;
                    done    <= 1'b1;
                    if (op_q == OP_ADD) carry <= add_full[WIDTH];
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slot_route_engine.sv
// Scoreboard bench for slot_route_engine: stimulus pushes hand-computed
// expectations, a negedge monitor checks them on every done pulse.
module tb_slot_route_engine;
    localparam int WIDTH   = 4;
    localparam int SLOTS   = 8;
    localparam int DELAY_W = 3;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [SLOTS*WIDTH-1:0] inp = '0;
    logic [SLOTS*WIDTH-1:0] out;
    logic                   done, carry;

    slot_route_engine_if #(.WIDTH(WIDTH), .SLOTS(SLOTS), .DELAY_W(DELAY_W)) bus ();

    slot_route_engine #(.WIDTH(WIDTH), .SLOTS(SLOTS), .DELAY_W(DELAY_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .inp   (inp),
        .out   (out),
        .done  (done),
        .carry (carry)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [SLOTS*WIDTH-1:0] out;
        logic                   carry;
        int                     cyc;
        string                  name;
    } exp_t;
    exp_t sbq[$];

    logic [WIDTH-1:0] es[SLOTS];
    logic             ec;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [SLOTS*WIDTH-1:0] pack_es();
        logic [SLOTS*WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < SLOTS; i++) r[i*WIDTH +: WIDTH] = es[i];
        return r;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && done) begin
            if (sbq.size() == 0) check("unexpected_done", 1, 0);
            else begin
                e = sbq.pop_front();
                check({e.name, "_out"},   out,   e.out);
                check({e.name, "_carry"}, carry, e.carry);
                check({e.name, "_lat"},   cyc,   e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_inp(int s, logic [WIDTH-1:0] v);
        inp[s*WIDTH +: WIDTH] = v;
    endtask

    task automatic clr_es();
        for (int i = 0; i < SLOTS; i++) es[i] = '0;
    endtask

    task automatic issue(string nm, logic [1:0] op, logic [2:0] d, logic [2:0] dst,
                         logic [2:0] src, bit push, output int acc);
        int n = 0;
        while (!bus.instr_ready && n < 100) begin tick(); n++; end
        check({nm, "_rdy"}, bus.instr_ready, 1);
        bus.instr       = {op, d, dst, src};
        bus.instr_valid = 1'b1;
        tick();
        acc = cyc;
        bus.instr_valid = 1'b0;
        if (push) sbq.push_back('{pack_es(), ec, acc + 1 + int'(d), nm});
    endtask

    // Counts busy cycles after an acceptance; optionally pokes a stray CLEAR mid-wait.
    task automatic ready_low(string nm, int exp, bit pulse);
        int n = 0;
        while (!bus.instr_ready && n < 50) begin
            n++;
            if (pulse) begin
                bus.instr       = '1;
                bus.instr_valid = (n == 2);
            end
            tick();
        end
        bus.instr_valid = 1'b0;
        check(nm, n, exp);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin tick(); n++; end
        tick();
    endtask

    initial begin
        int acc;
        int a[3];
        logic dn;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        clr_es();
        ec = 1'b0;

        repeat (3) tick();
        reset = 1'b0;
        check("rst_out",   out, 0);
        check("rst_done",  done, 0);
        check("rst_carry", carry, 0);
        check("rst_ready", bus.instr_ready, 1);

        // MOVE, zero delay
        set_inp(2, 4'h9); es[5] = 4'h9;
        issue("move_d0", 2'b00, 3'd0, 3'd5, 3'd2, 1, acc);
        ready_low("move_d0_busy", 1, 0);

        // MOVE with delay 5; input changes and stray valid during WAIT are ignored
        set_inp(0, 4'h3); es[7] = 4'h3;
        issue("move_d5", 2'b00, 3'd5, 3'd7, 3'd0, 1, acc);
        set_inp(0, 4'hA);
        ready_low("move_d5_busy", 6, 1);

        // ADD wrap with carry, then ADD without carry
        set_inp(1, 4'hF); es[1] = 4'hF;
        issue("load_f", 2'b00, 3'd0, 3'd1, 3'd1, 1, acc);
        set_inp(4, 4'h1); es[1] = 4'h0; ec = 1'b1;
        issue("add_wrap", 2'b01, 3'd0, 3'd1, 3'd4, 1, acc);
        set_inp(4, 4'h2); es[1] = 4'h2; ec = 1'b0;
        issue("add_2", 2'b01, 3'd0, 3'd1, 3'd4, 1, acc);

        for (int i = 0; i < SLOTS; i++) begin
            set_inp(i, WIDTH'(i + 1)); es[i] = WIDTH'(i + 1);
            issue("load", 2'b00, 3'd0, 3'(i), 3'(i), 1, acc);
        end
        set_inp(3, 4'hC); clr_es(); es[6] = 4'hC;
        issue("isolate", 2'b10, 3'd1, 3'd6, 3'd3, 1, acc);
        // 0xC + 0xF = 0x1B
        set_inp(0, 4'hF); es[6] = 4'hB; ec = 1'b1;
        issue("add_carry", 2'b01, 3'd2, 3'd6, 3'd0, 1, acc);
        clr_es();
        issue("clear", 2'b11, 3'd0, 3'd5, 3'd2, 1, acc);
        drain();

        // Full-scale delay aborted by reset
        set_inp(2, 4'h5);
        issue("abort", 2'b00, 3'd7, 3'd3, 3'd2, 0, acc);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ec = 1'b0;
        check("abort_out",   out, 0);
        check("abort_carry", carry, 0);
        check("abort_ready", bus.instr_ready, 1);
        dn = 1'b0;
        repeat (12) begin tick(); dn = dn | done; end
        check("abort_no_done", dn, 0);
        check("abort_out_late", out, 0);

        // Back-to-back MOVEs with valid held high
        set_inp(0, 4'h4); set_inp(1, 4'h5); set_inp(2, 4'h6);
        bus.instr_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            int n = 0;
            bus.instr = {2'b00, 3'd0, 3'(j), 3'(j)};
            es[j] = WIDTH'(4 + j);
            while (!bus.instr_ready && n < 20) begin tick(); n++; end
            tick();
            a[j] = cyc;
            sbq.push_back('{pack_es(), ec, a[j] + 1, "b2b"});
        end
        bus.instr_valid = 1'b0;
        check("b2b_gap01", a[1] - a[0], 2);
        check("b2b_gap12", a[2] - a[1], 2);
        drain();

        check("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/slot_route_engine.md
Name: slot_route_engine

Overview:
- Instruction-driven slot router: selects one of SLOTS input words, optionally combines it with a stored slot, and commits the result into a destination slot of an internal buffer after a programmable delay.
- Generalises the fixed 8x4 mux/demux decoder to parametrised width, slot count and delay.
- Adds a valid/ready instruction handshake, clear/isolate modes, add-with-carry and a done pulse.
- Sits between the switch/input bank and the 7-segment display drivers.

Parameters:
WIDTH, 4, bits per slot word
SLOTS, 8, number of input and buffer slots (power of two, >=2)
DELAY_W, 3, width of the instruction delay field
SEL_W (localparam), $clog2(SLOTS), width of the src/dst selects
INSTR_W (localparam), 2+DELAY_W+2*SEL_W, instruction width

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- instr_valid  input  1  instruction present
- instr_ready  output  1  engine can accept an instruction
- instr  input  INSTR_W  {op[1:0], delay[DELAY_W-1:0], dst[SEL_W-1:0], src[SEL_W-1:0]}, src in LSBs
- inp  input  SLOTS*WIDTH  flattened input words; slot i = inp[i*WIDTH +: WIDTH]
- out  output  SLOTS*WIDTH  flattened buffer contents, same packing
- done  output  1  one-cycle pulse after each commit
- carry  output  1  carry-out of the last committed ADD

Behaviour:
- Reset: clk rising edge with reset=1.
  - out=0 (all slots), done=0, carry=0, instr_ready=1, state=IDLE.
  - Aborts any in-flight instruction; nothing is committed.
  - Reset overrides every other input.
- Opcodes:
  - 00 MOVE: buf[dst] <= captured word.
  - 01 ADD: buf[dst] <= (buf[dst] + captured word) mod 2^WIDTH; carry <= bit WIDTH of the sum.
  - 10 ISOLATE: buf[dst] <= captured word, every other slot <= 0.
  - 11 CLEAR: all slots <= 0; src and dst ignored.
- States:
  - IDLE: instr_ready=1. On instr_valid=1, accept and capture inp[src] into an internal hold register; store op and dst.
    - delay=0 -> COMMIT.
    - delay=d>0 -> WAIT, counter loaded with d.
  - WAIT: instr_ready=0. Counter decrements each cycle; -> COMMIT when the counter reaches 1 in the current cycle.
  - COMMIT: instr_ready=0. Buffer updated at this edge; done=1 in the following cycle; -> IDLE.
- Latency and throughput:
  - Acceptance at edge k; buffer update at edge k+1+d; done high during cycle k+1+d .. k+2+d.
  - Next acceptance is possible at edge k+2+d.
  - Throughput: one instruction per d+2 cycles.
- inp is sampled only at acceptance; changes during WAIT are ignored.
- ADD reads buf[dst] at commit time, not at acceptance.
- carry updates only on ADD commits and holds through MOVE, ISOLATE and CLEAR.
- instr_valid outside IDLE is ignored: no queueing, no error.
- If instr_valid is held high, a new instruction is accepted on the edge where the engine returns to IDLE. Instr must be stable whenever valid=1 and ready=1.
- out is registered; it changes only at commit or reset edges.
- Full-scale values:
  - delay = 2^DELAY_W-1 waits that many cycles exactly.
  - src == dst is legal.
  - ADD wrap-around example: 0xF + 0x1 -> 0x0 with carry=1.

Test Plan:
- Reset, then MOVE src=2, dst=5, delay=0, inp[2]=0x9 -> out slot5=0x9 one edge after acceptance; done pulses one cycle; all other slots 0; instr_ready low for exactly 1 cycle.
- MOVE src=0, dst=7, delay=5, inp[0]=0x3, with inp[0] changed to 0xA during WAIT -> slot7=0x3 at acceptance+6 edges; instr_ready low for 6 cycles.
- Slot1=0xF, then ADD src=4 (inp[4]=0x1), dst=1 -> slot1=0x0, carry=1. Then ADD with 0x2 -> slot1=0x2, carry=0.
- Slots 0..7 loaded with 1..8, then ISOLATE src=3 (inp[3]=0xC), dst=6 -> slot6=0xC, all other slots 0. Then CLEAR -> all slots 0, carry unchanged.
- Accept MOVE with delay=7, assert reset 3 cycles later -> no commit; out all 0; done never pulses; instr_ready=1 the cycle after reset.
- instr_valid held high with back-to-back MOVEs at delay=0 -> accepted every 2nd cycle; pulses on instr_valid during WAIT/COMMIT are dropped.
